// File: rtl/qgpio_arb_pkg.sv
// Shared types, default sizing and the window range check for the GPIO access arbiter.
package qgpio_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CMD      = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_RESP     = 2'd3
   } state_e;

   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_NUM_SIGNALS    = 200;
   localparam int DEF_VALUE_WIDTH    = 32;
   localparam int DEF_TIMEOUT_CYCLES = 64;

   // A window is legal when it is 1..value_width bits wide and ends inside the bank.
   function automatic logic range_error(
      input int unsigned index,
      input int unsigned width,
      input int unsigned num_signals,
      input int unsigned value_width
   );
      return (width == 0) || (width > value_width) || ((index + width) > num_signals);
   endfunction

endpackage

// File: rtl/qgpio_rr_arbiter.sv
// Round-robin picker: first requester at or after rr_ptr wins, returned one-hot and encoded.
module qgpio_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               grant_any
);

   int w_pos;

   always_comb begin
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
      w_pos     = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         w_pos = (int'(rr_ptr) + off) % NUM_REQ;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!grant_any && (j == w_pos) && req[j]) begin
               grant_any = 1'b1;
               grant[j]  = 1'b1;
               grant_id  = ID_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/qgpio_access_arbiter.sv
// Shares one GPIO bank among NUM_REQ requesters: round-robin grant, range check,
// bank command/response handshake with timeout, one-cycle response to the winner.
module qgpio_access_arbiter
   import qgpio_arb_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int NUM_SIGNALS    = DEF_NUM_SIGNALS,
   parameter int VALUE_WIDTH    = DEF_VALUE_WIDTH,
   parameter int IDX_W          = $clog2(NUM_SIGNALS),
   parameter int WID_W          = $clog2(VALUE_WIDTH + 1),
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ-1:0]             req_write,
   input  logic [NUM_REQ*IDX_W-1:0]       req_index,
   input  logic [NUM_REQ*WID_W-1:0]       req_width,
   input  logic [NUM_REQ*VALUE_WIDTH-1:0] req_wdata,
   output logic                           resp_valid,
   output logic [ID_W-1:0]                resp_id,
   output logic                           resp_err,
   output logic [VALUE_WIDTH-1:0]         resp_rdata,
   output logic                           gpio_cmd_valid,
   input  logic                           gpio_cmd_ready,
   output logic                           gpio_cmd_write,
   output logic [IDX_W-1:0]               gpio_cmd_index,
   output logic [WID_W-1:0]               gpio_cmd_width,
   output logic [VALUE_WIDTH-1:0]         gpio_cmd_wdata,
   input  logic                           gpio_rsp_valid,
   input  logic [VALUE_WIDTH-1:0]         gpio_rsp_rdata
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

   state_e                 r_state;
   state_e                 w_state_next;
   logic [ID_W-1:0]        r_rr_ptr;
   logic [ID_W-1:0]        r_id;
   logic                   r_write;
   logic [IDX_W-1:0]       r_index;
   logic [WID_W-1:0]       r_width;
   logic [VALUE_WIDTH-1:0] r_wdata;
   logic [VALUE_WIDTH-1:0] r_rdata;
   logic                   r_err;
   logic [CNT_W-1:0]       r_cnt;

   logic [NUM_REQ-1:0]     w_grant;
   logic [ID_W-1:0]        w_grant_id;
   logic                   w_grant_any;
   logic                   w_range_err;
   logic                   w_timeout;
   logic [VALUE_WIDTH-1:0] w_mask;

   logic [IDX_W-1:0]       w_index_arr [NUM_REQ];
   logic [WID_W-1:0]       w_width_arr [NUM_REQ];
   logic [VALUE_WIDTH-1:0] w_wdata_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_index_arr[gi] = req_index[gi*IDX_W +: IDX_W];
         assign w_width_arr[gi] = req_width[gi*WID_W +: WID_W];
         assign w_wdata_arr[gi] = req_wdata[gi*VALUE_WIDTH +: VALUE_WIDTH];
      end
   endgenerate

   qgpio_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .req       (req_valid),
      .rr_ptr    (r_rr_ptr),
      .grant     (w_grant),
      .grant_id  (w_grant_id),
      .grant_any (w_grant_any)
   );

   assign w_range_err = range_error(32'(w_index_arr[w_grant_id]),
                                    32'(w_width_arr[w_grant_id]),
                                    NUM_SIGNALS, VALUE_WIDTH);

   // Counter runs from 0 on the first CMD cycle, so expiry lands TIMEOUT_CYCLES after CMD entry.
   assign w_timeout = (r_cnt == CNT_LAST);

   always_comb begin
      w_mask = '0;
      for (int b = 0; b < VALUE_WIDTH; b++) begin
         if (b < int'(r_width)) begin
            w_mask[b] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      req_ready    = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_any) begin
               req_ready    = w_grant;
               w_state_next = w_range_err ? ST_RESP : ST_CMD;
            end
         end
         ST_CMD: begin
            if (w_timeout) begin
               w_state_next = ST_RESP;
            end else if (gpio_cmd_ready) begin
               w_state_next = ST_WAIT_RSP;
            end
         end
         ST_WAIT_RSP: begin
            if (gpio_rsp_valid || w_timeout) begin
               w_state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
         r_id     <= '0;
         r_write  <= 1'b0;
         r_index  <= '0;
         r_width  <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant_any) begin
                  r_id    <= w_grant_id;
                  r_write <= req_write[w_grant_id];
                  r_index <= w_index_arr[w_grant_id];
                  r_width <= w_width_arr[w_grant_id];
                  r_wdata <= w_wdata_arr[w_grant_id];
                  r_err   <= w_range_err;
                  r_rdata <= '0;
                  r_cnt   <= '0;
               end
            end
            ST_CMD: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
               end
            end
            ST_WAIT_RSP: begin
               r_cnt <= r_cnt + CNT_W'(1);
               // A response arriving on the expiry cycle still counts as success.
               if (gpio_rsp_valid) begin
                  r_rdata <= r_write ? '0 : (gpio_rsp_rdata & w_mask);
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
               end
            end
            ST_RESP: begin
               r_rr_ptr <= (r_id == ID_LAST) ? '0 : (r_id + ID_W'(1));
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   assign gpio_cmd_valid = (r_state == ST_CMD);
   assign gpio_cmd_write = r_write;
   assign gpio_cmd_index = r_index;
   assign gpio_cmd_width = r_width;
   assign gpio_cmd_wdata = r_wdata;

   assign resp_valid = (r_state == ST_RESP);
   assign resp_id    = resp_valid ? r_id    : '0;
   assign resp_err   = resp_valid ? r_err   : 1'b0;
   assign resp_rdata = resp_valid ? r_rdata : '0;

endmodule

// File: doc/qgpio_access_arbiter.md
# qgpio_access_arbiter

Round-robin access controller sharing one GPIO signal bank (up to 200 signals, 32-bit set/get windows) among NUM_REQ requesters. Each requester issues a set (write) or get (read) of a contiguous bit window; the block grants one at a time, range-checks, forwards the command to the bank, enforces a response timeout, and returns the result to the winner. It sits between the per-agent GPIO access ports and the single bank port.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- NUM_SIGNALS, 200, signals in the bank
- VALUE_WIDTH, 32, maximum window width in bits
- IDX_W, $clog2(NUM_SIGNALS), signal index width
- WID_W, $clog2(VALUE_WIDTH+1), window-width field width
- TIMEOUT_CYCLES, 64, cycles allowed from command issue to bank response
- clk  in  1  sole clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot acceptance pulse
- req_write  in  NUM_REQ  1=set, 0=get
- req_index  in  NUM_REQ*IDX_W  first signal of window
- req_width  in  NUM_REQ*WID_W  window width, legal 1..VALUE_WIDTH
- req_wdata  in  NUM_REQ*VALUE_WIDTH  set value, LSB at req_index
- resp_valid  out  1  one-cycle completion pulse
- resp_id  out  $clog2(NUM_REQ)  requester being answered
- resp_err  out  1  range error or timeout
- resp_rdata  out  VALUE_WIDTH  get result, bits ≥ width zero
- gpio_cmd_valid / gpio_cmd_ready  out / in  1  bank command handshake
- gpio_cmd_write, gpio_cmd_index, gpio_cmd_width, gpio_cmd_wdata  out  1/IDX_W/WID_W/VALUE_WIDTH  registered command fields
- gpio_rsp_valid  in  1  bank completion pulse (set and get)
- gpio_rsp_rdata  in  VALUE_WIDTH  bank get data

## Operation
- FSM states: IDLE, CMD, WAIT_RSP, RESP.
- IDLE: if any req_valid, round-robin pick starting at rr_ptr; req_ready[winner]=1 combinationally that cycle; capture fields, id. Range check: width==0, width>VALUE_WIDTH, or index+width>NUM_SIGNALS (computed IDX_W+1 bits) → err flag, next RESP. Else next CMD.
- CMD: gpio_cmd_valid=1, fields stable until gpio_cmd_ready; then WAIT_RSP.
- WAIT_RSP: on gpio_rsp_valid capture rdata (masked to width; forced 0 for set) → RESP.
- Timeout: counter cleared on entering CMD, increments each cycle in CMD/WAIT_RSP; reaching TIMEOUT_CYCLES → RESP with err=1, rdata=0, gpio_cmd_valid dropped.
- RESP: resp_valid=1 for exactly one cycle; rr_ptr ← winner+1 mod NUM_REQ; → IDLE. No response backpressure.
- gpio_rsp_valid outside WAIT_RSP is ignored (late response after timeout discarded).
- Requester holds request fields until its req_ready; non-winners wait.

## Timing
- Reset: state IDLE, rr_ptr 0, all outputs 0 (req_ready, resp_*, gpio_cmd_*), counter 0.
- Legal path, ready bank: accept c0, cmd_valid c1, rsp earliest c2, resp_valid c3, next accept c4. Minimum 4 cycles/transaction.
- Error path: accept c0, resp_valid c1 with err, no bank command.
- Simultaneous gpio_rsp_valid and timeout expiry: response wins, err=0.
- Reset mid-transaction: abort immediately, no resp_valid; bank sees cmd_valid fall.
- Fairness: every requester served within NUM_REQ transactions of asserting.

## Structure
- Package qgpio_arb_pkg: state enum, default constants (NUM_SIGNALS=200, VALUE_WIDTH=32), range-check function.
- Sub-module qgpio_rr_arbiter: parameterised NUM_REQ round-robin picker (req vector, rr_ptr → one-hot grant, encoded id); rest is top-level FSM/datapath.

## Test plan
- Single get: req0 index 10 width 8, bank rdata 0xFFFF_FFFF → resp_id 0, rdata 0x0000_00FF, err 0, resp at c3.
- All four requesters valid continuously → grants 0,1,2,3,0 in order; after req2 served, rr_ptr=3.
- Range: index 195 width 8 → resp_err 1 at c1, gpio_cmd_valid never asserted; index 192 width 8 → legal.
- Bank never responds → resp_err 1, rdata 0 exactly TIMEOUT_CYCLES cycles after CMD entry; later gpio_rsp_valid ignored.
- cmd_ready held low 5 cycles → command fields stable throughout, issued on 6th.
- rst_n low during WAIT_RSP → outputs 0 asynchronously, no resp_valid, next request granted from req0.
